soma_sweep_scheduler: RTL

Time-multiplexed controller that shares one leaky integrate-and-fire update datapath across `N_NEURON` virtual soma instances. Between timesteps it arbitrates weighted input events from `N_REQ` synapse channels into per-neuron accumulators. On each `tick` it sweeps every neuron once, applying integrate, leak, threshold and refractory rules. It emits fired neuron indices on a valid/ready spike port toward the axon/router stage.

---
 rtl/soma_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/soma_sweep_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/soma_pkg.sv
// Shared state encoding and saturating arithmetic for the soma sweep scheduler.
package soma_pkg;

  localparam int VW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [VW_DEF-1:0] sat_add(input logic [VW_DEF-1:0] a,
                                                input logic [VW_DEF-1:0] b);
    logic [VW_DEF:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[VW_DEF] ? {VW_DEF{1'b1}} : s[VW_DEF-1:0];
  endfunction

  // a - b clamped at flr; an underflowing subtraction also lands on flr.
  function automatic logic [VW_DEF-1:0] floor_sub(input logic [VW_DEF-1:0] a,
                                                  input logic [VW_DEF-1:0] b,
                                                  input logic [VW_DEF-1:0] flr);
    logic [VW_DEF-1:0] d;
    if (a < b) return flr;
    d = a - b;
    return (d < flr) ? flr : d;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps, first requester wins.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    logic [PW:0] s;
    logic [PW-1:0] k;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    s       = '0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, ptr} + (PW+1)'(i);
      if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
      k = s[PW-1:0];
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/soma_sweep_scheduler.sv
// Shares one leaky integrate-and-fire datapath across N_NEURON virtual somas;
// events accumulate between ticks, each tick sweeps every neuron once.
//   state | meaning
//   IDLE  | arbitrate synapse events into accumulators, wait for tick
//   SWEEP | evaluate neuron idx, then drain any pending spike
//   DONE  | one-cycle tick_done pulse
module soma_sweep_scheduler
  import soma_pkg::*;
#(
  parameter int N_NEURON = 16,
  parameter int N_REQ    = 4,
  parameter int IDW      = $clog2(N_NEURON),
  parameter int VW       = VW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           vrest,
  input  logic [7:0]           vth,
  input  logic [7:0]           vlk,
  input  logic [7:0]           r_time,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*IDW-1:0] req_nid,
  input  logic [N_REQ*8-1:0]   req_weight,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 tick,
  input  logic                 kill_valid,
  input  logic [IDW-1:0]       kill_nid,
  output logic                 spike_valid,
  output logic [IDW-1:0]       spike_nid,
  input  logic                 spike_ready,
  output logic                 busy,
  output logic                 tick_done,
  output logic                 tick_miss
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDW-1:0] LAST = IDW'(N_NEURON - 1);

  state_t state, state_nxt;

  logic [VW-1:0]       v    [N_NEURON];
  logic [VW-1:0]       acc  [N_NEURON];
  logic [7:0]          refr [N_NEURON];
  logic [N_NEURON-1:0] dead;

  logic [PW-1:0]  rr_ptr;
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]  gnt_idx;
  logic           gnt_any;

  logic [IDW-1:0] idx;
  logic           swept;
  logic [VW-1:0]  p_vrest, p_vth, p_vlk;
  logic [7:0]     p_rtime;

  logic           accept, port_free, eval_en, eval_dead, fire;
  logic [IDW-1:0] w_nid;
  logic [7:0]     w_weight;
  logic [VW-1:0]  t_sum, v_next;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = SWEEP;
      SWEEP:   if (swept && port_free) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) ? gnt : '0;
    busy      = (state == SWEEP);
    tick_done = (state == DONE);
  end

  always_comb begin
    accept    = (state == IDLE) && gnt_any;
    w_nid     = req_nid[int'(gnt_idx)*IDW +: IDW];
    w_weight  = req_weight[int'(gnt_idx)*8 +: 8];
    port_free = !spike_valid || spike_ready;
    eval_en   = (state == SWEEP) && !swept && port_free;
    // A kill landing on the neuron under evaluation takes effect immediately.
    eval_dead = dead[idx] || (kill_valid && (kill_nid == idx));
    t_sum     = sat_add(v[idx], acc[idx]);
    v_next    = floor_sub(t_sum, p_vlk, p_vrest);
    fire      = (v_next >= p_vth);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_NEURON; i++) begin
        v[i]    <= '0;
        acc[i]  <= '0;
        refr[i] <= '0;
      end
      dead        <= '0;
      rr_ptr      <= '0;
      idx         <= '0;
      swept       <= 1'b0;
      p_vrest     <= '0;
      p_vth       <= '0;
      p_vlk       <= '0;
      p_rtime     <= '0;
      spike_valid <= 1'b0;
      spike_nid   <= '0;
      tick_miss   <= 1'b0;
    end else begin
      tick_miss <= tick && (state != IDLE);
      if (kill_valid) dead[kill_nid] <= 1'b1;
      if (accept) begin
        acc[w_nid] <= sat_add(acc[w_nid], VW'(w_weight));
        rr_ptr     <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
      end
      if (spike_valid && spike_ready) spike_valid <= 1'b0;
      if ((state == IDLE) && tick) begin
        p_vrest <= VW'(vrest);
        p_vth   <= VW'(vth);
        p_vlk   <= VW'(vlk);
        p_rtime <= r_time;
        idx     <= '0;
        swept   <= 1'b0;
      end
      if (eval_en) begin
        acc[idx] <= '0;
        if (idx == LAST) swept <= 1'b1;
        else             idx   <= idx + IDW'(1);
        if (!eval_dead) begin
          if (refr[idx] != 8'd0) begin
            refr[idx] <= refr[idx] - 8'd1;
            v[idx]    <= p_vrest;
          end else if (fire) begin
            v[idx]      <= p_vrest;
            refr[idx]   <= p_rtime;
            spike_valid <= 1'b1;
            spike_nid   <= idx;
          end else begin
            v[idx] <= v_next;
          end
        end
      end
    end
  end

endmodule
